gtfwizard_raw_buffbypass_tx_supervisor: RTL and testbench

- Sits directly downstream of the TX buffer-bypass controller in the GTF raw wrapper, on the same TX user clock.
- Consumes the controller's done/error outputs and arms on the GT tx reset-done.
- Re-requests the bypass procedure through the controller's start-user input on error or timeout, with a bounded retry count.
- Reports a single locked/failed status to the latency-measurement logic.

---
 rtl/gtfwizard_raw_bbsup_pkg.sv | 21 ++
 rtl/gtfwizard_raw_bbsup_bit_sync.sv | 26 ++
 rtl/gtfwizard_raw_buffbypass_tx_supervisor.sv | 172 +++++++++++++++++
 tb/tb_gtfwizard_raw_buffbypass_tx_supervisor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtfwizard_raw_bbsup_pkg.sv
// Shared definitions for the TX buffer-bypass supervisor.
// State encodings are visible on sup_state_out, so they are fixed here.
// Optional feature macro used by the supervisor: GTFWIZ_BBSUP_PHALIGN_MON_EN.
package gtfwizard_raw_bbsup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_RETRY     = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAILED    = 3'd4
  } bbsup_state_t;

  // Consecutive low phase-align samples in LOCKED that count as loss of lock.
  localparam int LOL_THRESHOLD = 8;
  localparam int LOL_CNT_W     = $clog2(LOL_THRESHOLD);

  // Width of the retry counter reported to the latency-measurement logic.
  localparam int RETRY_CNT_W = 8;

endpackage

// File: rtl/gtfwizard_raw_bbsup_bit_sync.sv
// Single-bit flop synchronizer of configurable depth for async GT status
// inputs. Synchronous reset clears the chain so the supervisor starts from
// a known "not ready" view.
module gtfwizard_raw_bbsup_bit_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gtfwizard_raw_buffbypass_tx_supervisor.sv
// Supervises the TX buffer-bypass controller: arms on GT tx reset-done,
// waits for the controller's done edge, re-requests the procedure on error
// or timeout with a bounded retry count, and reports locked/failed.
// Optional loss-of-lock monitor on txphaligndone_in is compiled in when
// GTFWIZ_BBSUP_PHALIGN_MON_EN is defined.
module gtfwizard_raw_buffbypass_tx_supervisor
  import gtfwizard_raw_bbsup_pkg::*;
#(
  parameter int P_TIMEOUT_CYCLES = 4096,
  parameter int P_MAX_RETRIES    = 3,
  parameter int P_SYNC_STAGES    = 3
) (
  input  logic       gtwiz_buffbypass_tx_clk_in,
  input  logic       gtwiz_buffbypass_tx_reset_in,
`ifdef GTFWIZ_BBSUP_PHALIGN_MON_EN
  input  logic       txphaligndone_in,
`endif
  input  logic       gtwiz_buffbypass_tx_resetdone_in,
  input  logic       buffbypass_done_in,
  input  logic       buffbypass_error_in,
  input  logic       sup_restart_in,
  output logic       gtwiz_buffbypass_tx_start_user_out,
  output logic       sup_locked_out,
  output logic       sup_failed_out,
  output logic [7:0] sup_retry_count_out,
  output logic [2:0] sup_state_out
);

  localparam int TIMER_W = $clog2(P_TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0]     TIMER_LAST  = TIMER_W'(P_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] MAX_RETRIES = RETRY_CNT_W'(P_MAX_RETRIES);
  localparam logic [RETRY_CNT_W-1:0] CNT_SAT     = '1;

  logic                   clk;
  logic                   rst;
  logic                   rd_sync;
  logic                   done_q;
  logic                   done_accept;
  logic                   lol_trip;
  bbsup_state_t           state_q;
  logic [TIMER_W-1:0]     timer_q;
  logic [RETRY_CNT_W-1:0] retry_cnt_q;
  logic                   start_q;
  logic                   locked_q;
  logic                   failed_q;

  assign clk = gtwiz_buffbypass_tx_clk_in;
  assign rst = gtwiz_buffbypass_tx_reset_in;

  gtfwizard_raw_bbsup_bit_sync #(.STAGES(P_SYNC_STAGES)) u_rd_sync (
    .clk (clk),
    .rst (rst),
    .d   (gtwiz_buffbypass_tx_resetdone_in),
    .q   (rd_sync)
  );

  // Done is a level that stays high from the previous run, so only its rising
  // edge counts; an edge coinciding with our own start pulse is stale.
  assign done_accept = buffbypass_done_in & ~done_q & ~start_q;

`ifdef GTFWIZ_BBSUP_PHALIGN_MON_EN
  logic                 ph_sync;
  logic [LOL_CNT_W-1:0] lol_cnt_q;

  gtfwizard_raw_bbsup_bit_sync #(.STAGES(P_SYNC_STAGES)) u_ph_sync (
    .clk (clk),
    .rst (rst),
    .d   (txphaligndone_in),
    .q   (ph_sync)
  );

  assign lol_trip = (state_q == ST_LOCKED) && !ph_sync &&
                    (lol_cnt_q == LOL_CNT_W'(LOL_THRESHOLD - 1));

  // Count consecutive low phase-align samples while locked.
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_LOCKED) || ph_sync) begin
      lol_cnt_q <= '0;
    end else begin
      lol_cnt_q <= lol_cnt_q + 1'b1;
    end
  end
`else
  assign lol_trip = 1'b0;
`endif

  // Supervisor FSM with registered start/locked/failed derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      start_q     <= 1'b0;
      locked_q    <= 1'b0;
      failed_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= buffbypass_done_in;
      start_q <= 1'b0;
      if ((state_q != ST_IDLE) && !rd_sync) begin
        // GT fell out of reset-done: drop everything and re-arm.
        state_q     <= ST_IDLE;
        timer_q     <= '0;
        retry_cnt_q <= '0;
        locked_q    <= 1'b0;
        failed_q    <= 1'b0;
      end else if (sup_restart_in && ((state_q == ST_WAIT_DONE) ||
                   (state_q == ST_LOCKED) || (state_q == ST_FAILED))) begin
        state_q     <= ST_WAIT_DONE;
        timer_q     <= '0;
        retry_cnt_q <= '0;
        start_q     <= 1'b1;
        locked_q    <= 1'b0;
        failed_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rd_sync) begin
              state_q <= ST_WAIT_DONE;
              timer_q <= '0;
            end
          end
          ST_WAIT_DONE: begin
            timer_q <= timer_q + 1'b1;
            if (done_accept) begin
              if (buffbypass_error_in) begin
                state_q <= ST_RETRY;
              end else begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else if (timer_q == TIMER_LAST) begin
              state_q <= ST_RETRY;
            end
          end
          ST_RETRY: begin
            if (retry_cnt_q == MAX_RETRIES) begin
              state_q  <= ST_FAILED;
              failed_q <= 1'b1;
            end else begin
              state_q     <= ST_WAIT_DONE;
              timer_q     <= '0;
              start_q     <= 1'b1;
              retry_cnt_q <= (retry_cnt_q == CNT_SAT) ? retry_cnt_q : retry_cnt_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (lol_trip) begin
              state_q  <= ST_RETRY;
              locked_q <= 1'b0;
            end
          end
          ST_FAILED: begin
            state_q <= ST_FAILED;
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            failed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gtwiz_buffbypass_tx_start_user_out = start_q;
  assign sup_locked_out                     = locked_q;
  assign sup_failed_out                     = failed_q;
  assign sup_retry_count_out                = retry_cnt_q;
  assign sup_state_out                      = state_q;

endmodule

// File: tb/tb_gtfwizard_raw_buffbypass_tx_supervisor.sv
// Bench for the TX buffer-bypass supervisor (P_TIMEOUT_CYCLES=16,
// P_MAX_RETRIES=2, P_SYNC_STAGES=3). Inputs change on the falling edge,
// outputs are sampled on the falling edge. Each attempt's outcome is
// predicted from the done delay / error / timeout rules and the retry budget;
// every start pulse is matched against a queue of expected retry counts.
module tb_gtfwizard_raw_buffbypass_tx_supervisor;

  localparam int T_TO   = 16;
  localparam int T_MAXR = 2;
  localparam int T_SYNC = 3;

  localparam int K_CLEAN = 0;
  localparam int K_ERR   = 1;
  localparam int K_TO    = 2;

  localparam int O_AGAIN  = 0;
  localparam int O_LOCKED = 1;
  localparam int O_FAILED = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RTRY = 3'd2;
  localparam logic [2:0] S_LOCK = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd;
  logic       done;
  logic       err;
  logic       restart;
  logic       ph;
  logic       start;
  logic       locked;
  logic       failed;
  logic [7:0] cnt;
  logic [2:0] st;

  int         total     = 0;
  int         bad       = 0;
  int         exp_count = 0;
  bit         mon_en    = 1'b0;
  logic [7:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  gtfwizard_raw_buffbypass_tx_supervisor #(
    .P_TIMEOUT_CYCLES (T_TO),
    .P_MAX_RETRIES    (T_MAXR),
    .P_SYNC_STAGES    (T_SYNC)
  ) dut (
    .gtwiz_buffbypass_tx_clk_in         (clk),
    .gtwiz_buffbypass_tx_reset_in       (rst),
`ifdef GTFWIZ_BBSUP_PHALIGN_MON_EN
    .txphaligndone_in                   (ph),
`endif
    .gtwiz_buffbypass_tx_resetdone_in   (rd),
    .buffbypass_done_in                 (done),
    .buffbypass_error_in                (err),
    .sup_restart_in                     (restart),
    .gtwiz_buffbypass_tx_start_user_out (start),
    .sup_locked_out                     (locked),
    .sup_failed_out                     (failed),
    .sup_retry_count_out                (cnt),
    .sup_state_out                      (st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every start pulse must be expected and carry the expected count.
  always @(negedge clk) begin
    if (mon_en) begin
      if (start === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("start_unexpected", start, 0);
        end else begin
          check("start_count", cnt, exp_q.pop_front());
        end
      end else begin
        check("start_level", start, 0);
      end
    end
  end

  // One bypass attempt starting in the current WAIT_DONE cycle (timer 0).
  // kind: clean/error done edge presented with timer=j, or no done (timeout).
  task automatic attempt(input int kind, input int j, output int outcome);
    int last;
    last = (kind == K_TO) ? (T_TO - 1) : j;
    for (int t = 0; t <= last; t++) begin
      check("att_wait_state", st, S_WAIT);
      check("att_wait_locked", locked, 0);
      if ((kind != K_TO) && (t == j)) begin
        done = 1'b1;
        err  = (kind == K_ERR);
      end
      step();
    end
    if (kind == K_CLEAN) begin
      check("att_locked", locked, 1);
      check("att_lock_state", st, S_LOCK);
      check("att_lock_count", cnt, exp_count);
      outcome = O_LOCKED;
    end else begin
      check("att_retry_state", st, S_RTRY);
      check("att_retry_locked", locked, 0);
      if (exp_count < T_MAXR) begin
        exp_count++;
        exp_q.push_back(8'(exp_count));
        step();
        check("att_rewait_state", st, S_WAIT);
        check("att_rewait_count", cnt, exp_count);
        done    = 1'b0;
        err     = 1'b0;
        outcome = O_AGAIN;
      end else begin
        step();
        check("att_fail_state", st, S_FAIL);
        check("att_failed", failed, 1);
        check("att_fail_count", cnt, exp_count);
        outcome = O_FAILED;
      end
    end
  endtask

  // Pulse restart; the start cycle becomes the first cycle of a new attempt.
  task automatic restart_now();
    restart   = 1'b1;
    exp_count = 0;
    exp_q.push_back(8'd0);
    step();
    restart = 1'b0;
    check("rs_state", st, S_WAIT);
    check("rs_count", cnt, 0);
    check("rs_locked", locked, 0);
    check("rs_failed", failed, 0);
    done = 1'b0;
    err  = 1'b0;
  endtask

  initial begin
    int o;
    int kind;
    rst = 1'b1; rd = 1'b0; done = 1'b0; err = 1'b0; restart = 1'b0; ph = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", st, S_IDLE);
    check("reset_locked", locked, 0);
    check("reset_failed", failed, 0);
    check("reset_count", cnt, 0);
    check("reset_start", start, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // Arm: resetdone rise reaches WAIT_DONE after sync depth + 1 cycles.
    rd = 1'b1;
    for (int k = 0; k < T_SYNC; k++) begin
      step();
      check("arm_idle", st, S_IDLE);
    end
    step();
    check("arm_wait", st, S_WAIT);
    attempt(K_CLEAN, 5, o);

    // Two error runs then a clean one.
    restart_now();
    attempt(K_ERR, $urandom_range(1, T_TO - 1), o);
    attempt(K_ERR, $urandom_range(1, T_TO - 1), o);
    attempt(K_CLEAN, $urandom_range(1, T_TO - 1), o);
    check("err_err_clean_outcome", o, O_LOCKED);

    // Three timeouts exhaust the budget; restart recovers from FAILED.
    restart_now();
    attempt(K_TO, 0, o);
    attempt(K_TO, 0, o);
    attempt(K_TO, 0, o);
    check("timeout_outcome", o, O_FAILED);
    repeat (3) step();
    check("failed_hold", failed, 1);
    restart_now();

    // Done edge in the final timer cycle beats the timeout.
    attempt(K_CLEAN, T_TO - 1, o);

    // Done edge coincident with our start pulse is stale and ignored.
    done = 1'b0;
    step();
    restart_now();
    done = 1'b1;
    attempt(K_TO, 0, o);
    attempt(K_CLEAN, $urandom_range(1, T_TO - 1), o);
    check("stale_count", cnt, 1);

    // Resetdone drops so its synced fall lands in RETRY with count 1.
    restart_now();
    attempt(K_ERR, $urandom_range(1, T_TO - 1), o);
    for (int t = 0; t <= 6; t++) begin
      check("rdrop_wait", st, S_WAIT);
      if (t == 6 - T_SYNC + 1) rd = 1'b0;
      if (t == 6) begin
        done = 1'b1;
        err  = 1'b1;
      end
      step();
    end
    check("rdrop_retry", st, S_RTRY);
    step();
    check("rdrop_idle", st, S_IDLE);
    check("rdrop_count", cnt, 0);
    check("rdrop_locked", locked, 0);
    check("rdrop_failed", failed, 0);
    exp_count = 0;
    done = 1'b0;
    err  = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("idle_restart_ignored", st, S_IDLE);
    step();
    rd = 1'b1;
    for (int k = 0; k < T_SYNC; k++) begin
      step();
      check("rearm_idle", st, S_IDLE);
    end
    step();
    check("rearm_wait", st, S_WAIT);
    attempt(K_CLEAN, $urandom_range(1, T_TO - 1), o);

    // Randomized sessions, each started by a restart.
    for (int s = 0; s < 8; s++) begin
      restart_now();
      do begin
        kind = $urandom_range(0, 2);
        attempt(kind, $urandom_range(1, T_TO - 1), o);
      end while (o == O_AGAIN);
      repeat ($urandom_range(0, 4)) step();
      check("session_locked_hold", locked, (o == O_LOCKED) ? 1 : 0);
      check("session_failed_hold", failed, (o == O_FAILED) ? 1 : 0);
    end

`ifdef GTFWIZ_BBSUP_PHALIGN_MON_EN
    // Loss-of-lock: 7 low samples keep lock, 8 drop it and retry.
    restart_now();
    attempt(K_CLEAN, 3, o);
    ph = 1'b0;
    for (int k = 0; k < 7; k++) step();
    ph = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("lol7_locked", locked, 1);
    end
    ph = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 1) ph = 1'b1;
      check("lol8_locked_pre", locked, 1);
    end
    ph = 1'b1;
    ph = 1'b0;
    for (int k = 0; k < 7; k++) step();
    ph = 1'b1;
    step();
    check("lol8_locked_pre2", locked, 1);
    ph = 1'b0;
    for (int k = 0; k < 8; k++) step();
    ph = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("lol8_still_locked", locked, 1);
    end
    step();
    check("lol8_unlocked", locked, 0);
    check("lol8_retry", st, S_RTRY);
    exp_count++;
    exp_q.push_back(8'(exp_count));
    step();
    check("lol8_rewait", st, S_WAIT);
    check("lol8_count", cnt, 1);
`endif

    repeat (2) step();
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
